// File: rtl/periph_mmio.sv
// periph_mmio: 32-byte MMIO window with a reload timer and interrupt, an LED
// register, and a hex display register. The display register drives a scanned
// 4-digit seven-segment output.
// The optional feature is enabled by defining PERIPH_SYSTICK_EN. It adds a
// free-running counter at offset 5.
// Reads are combinational. Writes and timer updates take effect at the clock edge.
module periph_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        sel,
  output logic        irq,
  output logic [15:0] led,
  output logic [3:0]  AN,
  output logic [7:0]  BCD
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_DIGI = 3'd4;
  localparam logic [2:0] OFF_SYST = 3'd5;

  logic [31:0]   th_q, th_d;
  logic [31:0]   tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [15:0]   led_q, led_d;
  logic [15:0]   digi_q, digi_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    bcd_q, bcd_d;
`ifdef PERIPH_SYSTICK_EN
  logic [31:0]   systick_q, systick_d;
`endif

  logic [2:0]  off;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;
  logic [3:0]  nibble;

  // Byte lane bits are ignored because only word accesses are supported.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[1:0];

  assign sel   = (Address[31:5] == BASE_ADDR[31:5]);
  assign off   = Address[4:2];
  assign wr_en = sel & MemWrite;
  assign rd_en = sel & MemRead;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    // Segment order is {g,f,e,d,c,b,a}, active-high.
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Combinational read mux. The output is zero whenever this is not a selected load.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (off)
        OFF_TH:   rdata = th_q;
        OFF_TL:   rdata = tl_q;
        OFF_TCON: rdata = {29'd0, tcon_q};
        OFF_LED:  rdata = {16'd0, led_q};
        OFF_DIGI: rdata = {16'd0, digi_q};
`ifdef PERIPH_SYSTICK_EN
        OFF_SYST: rdata = systick_q;
`else
        OFF_SYST: rdata = '0;
`endif
        default:  rdata = '0;
      endcase
    end
  end
  assign Read_data = rdata;

  // Next state for the timer and registers.
  // The hardware update is applied first. A software write to the same
  // register overrides it.
  // TL reloads from the current TH, so a TH write on an overflow edge takes
  // effect only at the next reload.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wr_en) begin
      case (off)
        OFF_TH:   th_d   = Write_data;
        OFF_TL:   tl_d   = Write_data;
        OFF_TCON: tcon_d = Write_data[2:0];
        OFF_LED:  led_d  = Write_data[15:0];
        OFF_DIGI: digi_d = Write_data[15:0];
        default:  ;
      endcase
    end
  end

  // Display scanner. The outputs are registered from the current digit index.
  always_comb begin
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + CW'(1);
      idx_d      = idx_q;
    end
    case (idx_q)
      2'd0:    nibble = digi_q[3:0];
      2'd1:    nibble = digi_q[7:4];
      2'd2:    nibble = digi_q[11:8];
      default: nibble = digi_q[15:12];
    endcase
    an_d  = ~(4'b0001 << idx_q);
    bcd_d = {1'b1, ~hex7(nibble)};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q       <= '0;
      tl_q       <= '0;
      tcon_q     <= '0;
      led_q      <= '0;
      digi_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      bcd_q      <= '1;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      tcon_q     <= tcon_d;
      led_q      <= led_d;
      digi_q     <= digi_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
    end
  end

`ifdef PERIPH_SYSTICK_EN
  // Free-running tick counter. It is read-only from software.
  always_comb begin
    systick_d = systick_q + 32'd1;
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (reset) systick_q <= '0;
    else       systick_q <= systick_d;
  end
`endif

  assign irq = tcon_q[2];
  assign led = led_q;
  assign AN  = an_q;
  assign BCD = bcd_q;

endmodule

// File: tb/tb_periph_mmio.sv
// Self-checking bench for periph_mmio. It uses a directed vector table,
// hand-written timer and scanner sequences, and a randomized phase.
// Every output is compared against a behavioural model kept in this file.
module tb_periph_mmio;

  localparam int unsigned DIV = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [26:0] BASE_HI = 27'(BASE >> 5);
`ifdef PERIPH_SYSTICK_EN
  localparam logic [31:0] ST_AT5 = 32'd5;
  localparam logic [31:0] ST_DELTA = 32'd10;
`else
  localparam logic [31:0] ST_AT5 = 32'd0;
  localparam logic [31:0] ST_DELTA = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        sel;
  logic        irq;
  logic [15:0] led;
  logic [3:0]  AN;
  logic [7:0]  BCD;

  periph_mmio #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
    .sel(sel), .irq(irq), .led(led), .AN(AN), .BCD(BCD)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [15:0] m_led, m_digi;
  int unsigned m_edges;
  logic [3:0]  m_an;
  logic [7:0]  m_bcd;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return a[31:5] == BASE_HI;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    logic [2:0] o;
    o = a[4:2];
    if (!rd || !in_win(a)) return 32'd0;
    case (o)
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_tcon};
      3'd3: return {16'd0, m_led};
      3'd4: return {16'd0, m_digi};
`ifdef PERIPH_SYSTICK_EN
      3'd5: return m_systick;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_digi = '0; m_systick = '0;
    m_edges = 0; m_an = 4'hF; m_bcd = 8'hFF;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic wr);
    logic [15:0] old_digi, sh;
    int unsigned idx;
    old_digi = m_digi;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        m_tl = m_th;
        if (m_tcon[1]) m_tcon[2] = 1'b1;
      end else begin
        m_tl = m_tl + 32'd1;
      end
    end
    if (wr && in_win(a)) begin
      case (a[4:2])
        3'd0: m_th = d;
        3'd1: m_tl = d;
        3'd2: m_tcon = d[2:0];
        3'd3: m_led = d[15:0];
        3'd4: m_digi = d[15:0];
        default: ;
      endcase
    end
    m_systick = m_systick + 32'd1;
    m_edges++;
    idx = ((m_edges - 1) / DIV) % 4;
    sh = old_digi >> (4 * idx);
    m_an = an_tab[idx];
    m_bcd = glyph[sh[3:0]];
  endtask

  // One bus cycle. Inputs are driven at negedge. Combinational outputs are
  // checked before the edge, and registered outputs are checked 1 ns after it.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic rd,
                      input logic wr, output logic [31:0] rdat);
    @(negedge clk);
    reset = 1'b0; Address = a; Write_data = d; MemRead = rd; MemWrite = wr;
    #1;
    chk("sel", {31'd0, sel}, {31'd0, in_win(a)});
    chk("read_data", Read_data, m_read(a, rd));
    rdat = Read_data;
    @(posedge clk);
    model_edge(a, d, wr);
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_tcon[2]});
    chk("led", {16'd0, led}, {16'd0, m_led});
    chk("an", {28'd0, AN}, {28'd0, m_an});
    chk("bcd", {24'd0, BCD}, {24'd0, m_bcd});
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_led", {16'd0, led}, 32'd0);
    chk("rst_an", {28'd0, AN}, 32'hF);
    chk("rst_bcd", {24'd0, BCD}, 32'hFF);
    chk("rst_rdata", Read_data, 32'd0);
  endtask

  task automatic wr(input int unsigned o, input logic [31:0] d);
    logic [31:0] r;
    step(BASE + 32'(o * 4), d, 1'b0, 1'b1, r);
  endtask

  task automatic rdx(input int unsigned o, input logic [31:0] exp, input string nm);
    logic [31:0] r;
    step(BASE + 32'(o * 4), 32'd0, 1'b1, 1'b0, r);
    chk(nm, r, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [26];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, r1, r2, a, d;
    logic [3:0] scan_an [4];
    logic [7:0] scan_bcd [4];
    scan_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    scan_bcd = '{8'h8E, 8'h88, 8'hA4, 8'hF9};

    for (int k = 0; k < 8; k++) tbl[k] = '{BASE + 32'(k * 4), 32'd0, 1'b1, 1'b0, 32'd0};
    tbl[5]  = '{BASE + 32'h14, 32'd0, 1'b1, 1'b0, ST_AT5};
    tbl[8]  = '{BASE + 32'h00, 32'h1234_5678, 1'b0, 1'b1, 32'd0};
    tbl[9]  = '{BASE + 32'h00, 32'd0, 1'b1, 1'b0, 32'h1234_5678};
    tbl[10] = '{BASE + 32'h0C, 32'hABCD_1234, 1'b0, 1'b1, 32'd0};
    tbl[11] = '{BASE + 32'h0C, 32'd0, 1'b1, 1'b0, 32'h0000_1234};
    tbl[12] = '{BASE + 32'h10, 32'hFFFF_12AF, 1'b0, 1'b1, 32'd0};
    tbl[13] = '{BASE + 32'h10, 32'd0, 1'b1, 1'b0, 32'h0000_12AF};
    tbl[14] = '{BASE + 32'h08, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'd0};
    tbl[15] = '{BASE + 32'h08, 32'd0, 1'b1, 1'b0, 32'd0};
    tbl[16] = '{BASE + 32'h18, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0};
    tbl[17] = '{BASE + 32'h18, 32'd0, 1'b1, 1'b0, 32'd0};
    tbl[18] = '{BASE + 32'h04, 32'd5, 1'b0, 1'b1, 32'd0};
    tbl[19] = '{BASE + 32'h04, 32'd0, 1'b1, 1'b0, 32'd5};
    tbl[20] = '{BASE + 32'h20, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0};
    tbl[21] = '{BASE + 32'h20, 32'd0, 1'b1, 1'b0, 32'd0};
    tbl[22] = '{BASE + 32'h0E, 32'd0, 1'b1, 1'b0, 32'h0000_1234};
    tbl[23] = '{BASE + 32'h00, 32'd0, 1'b1, 1'b0, 32'h1234_5678};
    tbl[24] = '{BASE + 32'h14, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0};
    tbl[25] = '{BASE + 32'h1C, 32'd0, 1'b1, 1'b0, 32'd0};

    do_reset(2);
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, r);
      if (tbl[i].rd) chk($sformatf("vec%0d", i), r, tbl[i].exp);
      if (i == 0) begin
        chk("an_first", {28'd0, AN}, 32'hE);
        chk("bcd_first", {24'd0, BCD}, 32'hC0);
      end
    end

    // Overflow sequence, interrupt set, then cleared by software.
    wr(0, 32'hFFFF_FFF0); wr(1, 32'hFFFF_FFFE); wr(2, 32'd3);
    rdx(1, 32'hFFFF_FFFE, "tl_pre");
    rdx(1, 32'hFFFF_FFFF, "tl_max");
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rdx(1, 32'hFFFF_FFF0, "tl_reload");
    wr(2, 32'd3);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rdx(2, 32'd3, "tcon_after_clr");
    rdx(1, 32'hFFFF_FFF3, "tl_running");

    // TCON write on the overflow edge.
    wr(2, 32'd0); wr(0, 32'h55); wr(1, 32'hFFFF_FFFE); wr(2, 32'd3);
    rdx(1, 32'hFFFF_FFFE, "tl_pre2");
    wr(2, 32'd7);
    rdx(1, 32'h55, "tl_eq_th");
    rdx(2, 32'd7, "tcon_wr_wins");

    // TL write on the overflow edge.
    wr(2, 32'd0); wr(1, 32'hFFFF_FFFE); wr(2, 32'd1);
    rdx(1, 32'hFFFF_FFFE, "tl_pre3");
    wr(1, 32'd5);
    rdx(1, 32'd5, "tl_wr_wins");

    // TH write on the overflow edge. TL reloads the old TH.
    wr(2, 32'd0); wr(0, 32'hAA); wr(1, 32'hFFFF_FFFE); wr(2, 32'd1);
    rdx(1, 32'hFFFF_FFFE, "tl_pre4");
    wr(0, 32'hBB);
    rdx(1, 32'hAA, "tl_old_th");
    rdx(0, 32'hBB, "th_new");

    // Scanner walk over DIGI = 12AF.
    do_reset(1);
    wr(4, 32'h12AF);
    chk("scan_an1", {28'd0, AN}, 32'hE);
    chk("scan_bcd1", {24'd0, BCD}, 32'hC0);
    for (int j = 2; j <= 16; j++) begin
      step(BASE, 32'd0, 1'b0, 1'b0, r);
      chk($sformatf("scan_an%0d", j), {28'd0, AN}, {28'd0, scan_an[(j - 1) / 4]});
      chk($sformatf("scan_bcd%0d", j), {24'd0, BCD}, {24'd0, scan_bcd[(j - 1) / 4]});
    end

    // Reset in the middle of a count with an interrupt pending.
    wr(1, 32'hFFFF_FFFE); wr(2, 32'd3);
    for (int j = 0; j < 3; j++) step(BASE, 32'd0, 1'b0, 1'b0, r);
    chk("irq_pending", {31'd0, irq}, 32'd1);
    do_reset(1);
    for (int k = 0; k < 5; k++) rdx(k, 32'd0, $sformatf("post_rst%0d", k));

    // Systick read delta.
    step(BASE + 32'h14, 32'd0, 1'b1, 1'b0, r1);
    for (int j = 0; j < 9; j++) step(BASE, 32'd0, 1'b0, 1'b0, r);
    step(BASE + 32'h14, 32'd0, 1'b1, 1'b0, r2);
    chk("systick_delta", r2 - r1, ST_DELTA);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int unsigned o;
      o = $urandom_range(0, 8);
      if (o == 8) a = BASE ^ (32'd1 << $urandom_range(5, 31));
      else a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      if (o == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
      step(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
